ffa_preproc: RTL and testbench
==============================

# ffa_preproc

Parametrised pre-processing stage for the 2-parallel fast-FIR (FFA) datapath. It splits each incoming sample pair into even/odd streams and forms the full-precision sum a+b under a valid/ready handshake. It holds a double-buffered coefficient bank (h0, h1, h01 = h0+h1) that is loaded serially, one tap per cycle, and committed atomically between samples. It sits between the input interface and the three sub-filter arrays.

## Interface
- NR_STAGES, 32: FIR taps; even, ≥ 2; HALF = NR_STAGES/2.
- DWIDTH, 16: sample and coefficient width, signed two's complement.
- SWIDTH, DWIDTH+1: width of the sum outputs (a+b, h0+h1).
- clk  in  1: single clock, rising edge.
- rst  in  1: asynchronous, active-low reset.
- in_valid  in  1: data_in is valid.
- in_ready  out  1: stage accepts data_in this cycle.
- data_in  in  2*DWIDTH: {a, b}; a = bits [0:DWIDTH-1] (even sample), b = the rest.
- out_valid  out  1: data outputs are valid.
- out_ready  in  1: downstream accepts outputs.
- data_a_out  out  DWIDTH: registered a.
- data_b_out  out  DWIDTH: registered b.
- data_ab_out  out  SWIDTH: registered sign-extended a+b.
- coef_start  in  1: pulse; restarts the coefficient load at tap 0.
- coef_valid  in  1: coef_in carries the next tap.
- coef_ready  out  1: low while a commit is pending.
- coef_in  in  DWIDTH: tap value, in order tap 0 … NR_STAGES-1.
- coef_done  out  1: one-cycle pulse when a new bank becomes active.
- h0_out, h1_out  out  HALF*DWIDTH: active bank; element k at [k*DWIDTH +: DWIDTH].
- h01_out  out  HALF*SWIDTH: active bank; element k at [k*SWIDTH +: SWIDTH].

## Operation
- Data path: one output register stage. Input transfer = in_valid & in_ready. in_ready = !out_valid | out_ready.
- On an input transfer, the output registers load a, b and sext(a)+sext(b) (SWIDTH, no overflow), and out_valid is set. On an output transfer with no input transfer, out_valid clears.
- Coefficient load: tap index counter idx runs 0…NR_STAGES-1. On each coef_valid & coef_ready:
  - even idx writes shadow h0[idx/2];
  - odd idx writes shadow h1[(idx-1)/2];
  - idx increments.
- On acceptance of tap NR_STAGES-1: idx wraps to 0 and commit_pending is set.
- Commit: in the first cycle with commit_pending and no input transfer, the shadow bank is copied to the active bank, with h01[k] = sext(h0[k]) + sext(h1[k]). commit_pending clears and coef_done pulses in the next cycle.
- Commit ordering: a sample accepted in the same cycle as a pending commit uses the old bank. The first sample accepted after the commit uses the new bank.
- coef_ready = !commit_pending.
- coef_start: sets idx to 0 and leaves the shadow contents as they are (partial loads are overwritten). It has priority over a coincident coef_valid, and that tap is dropped. coef_start while commit_pending is ignored.
- The active bank never changes except at a commit. A partial load never becomes visible.

## Timing
- Reset (rst low, async):
  - out_valid = 0;
  - data_a_out, data_b_out, data_ab_out = 0;
  - active and shadow banks = 0, so h0_out, h1_out, h01_out = 0;
  - idx = 0, commit_pending = 0, coef_done = 0.
- Reset mid-load or mid-stream discards everything. Outputs are valid only after deassertion plus a new transfer.
- Data latency: 1 cycle from input transfer to out_valid. Full throughput of 1 pair per cycle when out_ready = 1.
- Backpressure: with out_valid & !out_ready, in_ready = 0 and the outputs hold stable.
- Commit latency: at least 1 cycle after the last tap. It is deferred while input transfers occur every cycle (starvation is acceptable; the upstream is required to leave gaps when reloading).
- coef_done is asserted in the cycle the new h*_out values first appear.

## Structure
- Shared package ffa_pkg: HALF, SWIDTH derivation, and a function for the tap-to-bank index (even → h0[i/2], odd → h1[(i-1)/2]), reused by the post-processing block.
- Sub-module ffa_coef_bank: idx counter, shadow/active registers, commit logic, h01 adders. The top level holds the data handshake register.

## Test plan
- Reset, then load taps 1…32 (NR_STAGES=32) -> coef_done pulses once; h0 = {1,3,…,31}, h1 = {2,4,…,32}, h01 = {3,7,…,63}.
- Stream {a=32767, b=32767} -> data_ab_out = 65534 (17-bit); stream {a=-32768, b=-32768} -> -65536. Both arrive 1 cycle after the transfer.
- Hold out_ready = 0 for 3 cycles with in_valid = 1 -> in_ready = 0, outputs frozen; on release, 1 pair per cycle with no loss or duplication.
- Load 10 taps, pulse coef_start, then load the full 32 taps of 5 -> active bank becomes all 5 (h01 = 10) and is unchanged before the commit.
- Finish a load while streaming continuously, then insert one idle cycle -> commit happens in that idle cycle and coef_done follows; coef_valid is ignored (coef_ready = 0) while pending.
- Assert rst low mid-stream and mid-load -> all outputs 0 immediately, without a clock edge.

Source files
------------

// File: rtl/ffa_pkg.sv
// rtl/ffa_pkg.sv - shared FFA parameter derivations and tap-to-bank mapping
package ffa_pkg;

  localparam int TAP_IDX_W = 16;

  typedef enum logic {
    BANK_H0 = 1'b0,
    BANK_H1 = 1'b1
  } bank_e;

  typedef struct packed {
    bank_e                bank;
    logic [TAP_IDX_W-1:0] slot;
  } tap_loc_t;

  function automatic int half_of(input int nr_stages);
    return nr_stages / 2;
  endfunction

  function automatic int swidth_of(input int dwidth);
    return dwidth + 1;
  endfunction

  // Even taps go to h0[i/2], odd taps to h1[(i-1)/2]; both are i>>1.
  function automatic tap_loc_t tap_to_bank(input logic [TAP_IDX_W-1:0] tap);
    tap_loc_t loc;
    loc.bank = tap[0] ? BANK_H1 : BANK_H0;
    loc.slot = tap >> 1;
    return loc;
  endfunction

endpackage

// File: rtl/ffa_coef_bank.sv
// rtl/ffa_coef_bank.sv - serial coefficient loader with shadow/active banks and h0+h1 sums
module ffa_coef_bank
  import ffa_pkg::*;
#(
  parameter int NR_STAGES = 32,
  parameter int DWIDTH    = 16,
  parameter int SWIDTH    = DWIDTH + 1,
  localparam int HALF     = NR_STAGES / 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_xfer,
  input  logic                     coef_start,
  input  logic                     coef_valid,
  output logic                     coef_ready,
  input  logic [DWIDTH-1:0]        coef_in,
  output logic                     coef_done,
  output logic [HALF*DWIDTH-1:0]   h0_out,
  output logic [HALF*DWIDTH-1:0]   h1_out,
  output logic [HALF*SWIDTH-1:0]   h01_out
);

  localparam int IW = $clog2(NR_STAGES);

  logic [IW-1:0]     idx_q, idx_d;
  logic              pending_q, pending_d;
  logic              done_q;
  logic [DWIDTH-1:0] sh0_q  [HALF];
  logic [DWIDTH-1:0] sh1_q  [HALF];
  logic [DWIDTH-1:0] act0_q [HALF];
  logic [DWIDTH-1:0] act1_q [HALF];
  logic [SWIDTH-1:0] act01_q[HALF];

  logic     restart, tap_accept, last_tap, commit_now;
  tap_loc_t loc;

  assign coef_ready = !pending_q;
  assign restart    = coef_start && !pending_q;
  assign tap_accept = coef_valid && !pending_q && !coef_start;
  assign last_tap   = (idx_q == IW'(NR_STAGES - 1));
  // A sample taking the old bank this cycle defers the swap to the next idle cycle.
  assign commit_now = pending_q && !in_xfer;
  assign loc        = tap_to_bank(TAP_IDX_W'(idx_q));
  assign coef_done  = done_q;

  always_comb begin
    idx_d     = idx_q;
    pending_d = pending_q;
    if (commit_now) pending_d = 1'b0;
    if (restart) begin
      idx_d = '0;
    end else if (tap_accept) begin
      if (last_tap) begin
        idx_d     = '0;
        pending_d = 1'b1;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q     <= '0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      for (int k = 0; k < HALF; k++) begin
        sh0_q[k]   <= '0;
        sh1_q[k]   <= '0;
        act0_q[k]  <= '0;
        act1_q[k]  <= '0;
        act01_q[k] <= '0;
      end
    end else begin
      idx_q     <= idx_d;
      pending_q <= pending_d;
      done_q    <= commit_now;
      for (int k = 0; k < HALF; k++) begin
        if (tap_accept && loc.slot == TAP_IDX_W'(k)) begin
          if (loc.bank == BANK_H0) sh0_q[k] <= coef_in;
          else                     sh1_q[k] <= coef_in;
        end
        if (commit_now) begin
          act0_q[k]  <= sh0_q[k];
          act1_q[k]  <= sh1_q[k];
          act01_q[k] <= SWIDTH'($signed(sh0_q[k])) + SWIDTH'($signed(sh1_q[k]));
        end
      end
    end
  end

  for (genvar k = 0; k < HALF; k++) begin : g_out
    assign h0_out[k*DWIDTH +: DWIDTH]  = act0_q[k];
    assign h1_out[k*DWIDTH +: DWIDTH]  = act1_q[k];
    assign h01_out[k*SWIDTH +: SWIDTH] = act01_q[k];
  end

endmodule

// File: rtl/ffa_preproc.sv
// rtl/ffa_preproc.sv - 2-parallel FFA pre-processing: even/odd split, a+b, coefficient bank
module ffa_preproc
  import ffa_pkg::*;
#(
  parameter int NR_STAGES = 32,
  parameter int DWIDTH    = 16,
  parameter int SWIDTH    = swidth_of(DWIDTH),
  localparam int HALF     = half_of(NR_STAGES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2*DWIDTH-1:0]      data_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DWIDTH-1:0]        data_a_out,
  output logic [DWIDTH-1:0]        data_b_out,
  output logic [SWIDTH-1:0]        data_ab_out,
  input  logic                     coef_start,
  input  logic                     coef_valid,
  output logic                     coef_ready,
  input  logic [DWIDTH-1:0]        coef_in,
  output logic                     coef_done,
  output logic [HALF*DWIDTH-1:0]   h0_out,
  output logic [HALF*DWIDTH-1:0]   h1_out,
  output logic [HALF*SWIDTH-1:0]   h01_out
);

  logic              out_valid_q, out_valid_d;
  logic [DWIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [SWIDTH-1:0] ab_q, ab_d;
  logic [DWIDTH-1:0] a_in, b_in;
  logic              in_xfer;

  assign a_in     = data_in[DWIDTH-1:0];
  assign b_in     = data_in[2*DWIDTH-1:DWIDTH];
  assign in_ready = !out_valid_q || out_ready;
  assign in_xfer  = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    ab_d        = ab_q;
    if (in_xfer) begin
      out_valid_d = 1'b1;
      a_d         = a_in;
      b_d         = b_in;
      ab_d        = SWIDTH'($signed(a_in)) + SWIDTH'($signed(b_in));
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      ab_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ab_q        <= ab_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign data_a_out  = a_q;
  assign data_b_out  = b_q;
  assign data_ab_out = ab_q;

  ffa_coef_bank #(
    .NR_STAGES(NR_STAGES),
    .DWIDTH   (DWIDTH),
    .SWIDTH   (SWIDTH)
  ) u_coef_bank (
    .clk       (clk),
    .rst       (rst),
    .in_xfer   (in_xfer),
    .coef_start(coef_start),
    .coef_valid(coef_valid),
    .coef_ready(coef_ready),
    .coef_in   (coef_in),
    .coef_done (coef_done),
    .h0_out    (h0_out),
    .h1_out    (h1_out),
    .h01_out   (h01_out)
  );

endmodule

// File: tb/tb_ffa_preproc.sv
// tb/tb_ffa_preproc.sv - directed self-checking bench for ffa_preproc
module tb_ffa_preproc;

  localparam int NS = 32;
  localparam int DW = 16;
  localparam int SW = 17;
  localparam int HF = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2*DW-1:0] data_in = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [DW-1:0]   data_a_out, data_b_out;
  logic [SW-1:0]   data_ab_out;
  logic            coef_start = 1'b0;
  logic            coef_valid = 1'b0;
  logic            coef_ready;
  logic [DW-1:0]   coef_in = '0;
  logic            coef_done;
  logic [HF*DW-1:0] h0_out, h1_out;
  logic [HF*SW-1:0] h01_out;

  int total = 0;
  int bad   = 0;
  logic [HF*DW-1:0] e0, e1;
  logic [HF*SW-1:0] e01;

  ffa_preproc #(.NR_STAGES(NS), .DWIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_a_out(data_a_out), .data_b_out(data_b_out), .data_ab_out(data_ab_out),
    .coef_start(coef_start), .coef_valid(coef_valid), .coef_ready(coef_ready),
    .coef_in(coef_in), .coef_done(coef_done),
    .h0_out(h0_out), .h1_out(h1_out), .h01_out(h01_out)
  );

  always #5 clk = ~clk;

  function automatic logic [2*DW-1:0] pk(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return {b, a};
  endfunction

  task automatic send_tap(input logic [DW-1:0] v);
    coef_valid = 1'b1;
    coef_in    = v;
    @(posedge clk); #1;
  endtask

  task automatic wait_done(output bit found);
    found = 1'b0;
    for (int c = 0; c < 6 && !found; c++) begin
      @(posedge clk); #1;
      if (coef_done) found = 1'b1;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    total++; if (data_ab_out !== '0) begin bad++; $display("FAIL reset_ab got=%0h exp=0", data_ab_out); end
    total++; if (h0_out !== '0 || h1_out !== '0 || h01_out !== '0) begin bad++; $display("FAIL reset_bank got h0=%0h h1=%0h h01=%0h exp=0", h0_out, h1_out, h01_out); end
    total++; if (coef_done !== 1'b0 || coef_ready !== 1'b1) begin bad++; $display("FAIL reset_coef got done=%0b ready=%0b exp done=0 ready=1", coef_done, coef_ready); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_coef_load;
    bit found;
    for (int i = 0; i < NS; i++) send_tap(DW'(i + 1));
    coef_valid = 1'b0;
    total++; if (coef_ready !== 1'b0) begin bad++; $display("FAIL load_pending_ready got=%0b exp=0", coef_ready); end
    total++; if (h0_out !== '0) begin bad++; $display("FAIL load_early_bank got=%0h exp=0", h0_out); end
    wait_done(found);
    total++; if (!found) begin bad++; $display("FAIL load_done_timeout got=0 exp=1"); end
    for (int k = 0; k < HF; k++) begin
      e0[k*DW +: DW]  = DW'(2*k + 1);
      e1[k*DW +: DW]  = DW'(2*k + 2);
      e01[k*SW +: SW] = SW'(4*k + 3);
    end
    total++; if (h0_out !== e0) begin bad++; $display("FAIL load_h0 got=%0h exp=%0h", h0_out, e0); end
    total++; if (h1_out !== e1) begin bad++; $display("FAIL load_h1 got=%0h exp=%0h", h1_out, e1); end
    total++; if (h01_out !== e01) begin bad++; $display("FAIL load_h01 got=%0h exp=%0h", h01_out, e01); end
    @(posedge clk); #1;
    total++; if (coef_done !== 1'b0) begin bad++; $display("FAIL load_done_pulse got=%0b exp=0", coef_done); end
  endtask

  task automatic test_sum;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    data_in   = pk(16'd32767, 16'd32767);
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1 || data_ab_out !== 17'd65534) begin bad++; $display("FAIL sum_max got v=%0b ab=%0h exp v=1 ab=%0h", out_valid, data_ab_out, 17'd65534); end
    data_in = pk(16'h8000, 16'h8000);
    @(posedge clk); #1;
    total++; if (data_ab_out !== 17'h10000) begin bad++; $display("FAIL sum_min got=%0h exp=10000", data_ab_out); end
    data_in = pk(16'd5, 16'hFFFD);
    @(posedge clk); #1;
    total++; if (data_a_out !== 16'd5 || data_b_out !== 16'hFFFD || data_ab_out !== 17'd2) begin bad++; $display("FAIL sum_split got a=%0h b=%0h ab=%0h exp a=5 b=fffd ab=2", data_a_out, data_b_out, data_ab_out); end
    in_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sum_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_backpressure;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    data_in   = pk(16'd100, 16'd200);
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1 || data_a_out !== 16'd100) begin bad++; $display("FAIL bp_first got v=%0b a=%0d exp v=1 a=100", out_valid, data_a_out); end
    data_in = pk(16'd101, 16'd201);
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%0b exp=0", in_ready); end
    repeat (3) begin
      @(posedge clk); #1;
      total++; if (data_a_out !== 16'd100 || data_ab_out !== 17'd300 || in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold got a=%0d ab=%0d rdy=%0b exp a=100 ab=300 rdy=0", data_a_out, data_ab_out, in_ready); end
    end
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1 || data_a_out !== DW'(100 + i) || data_ab_out !== SW'(300 + 2*i)) begin bad++; $display("FAIL bp_release%0d got a=%0d ab=%0d exp a=%0d ab=%0d", i, data_a_out, data_ab_out, 100 + i, 300 + 2*i); end
      data_in = pk(DW'(101 + i), DW'(201 + i));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_restart;
    bit found;
    for (int i = 0; i < 10; i++) send_tap(16'd9);
    coef_start = 1'b1;
    send_tap(16'd77);
    coef_start = 1'b0;
    for (int i = 0; i < NS - 1; i++) send_tap(16'd5);
    total++; if (coef_ready !== 1'b1 || h0_out !== e0) begin bad++; $display("FAIL restart_early got rdy=%0b h0=%0h exp rdy=1 h0=%0h", coef_ready, h0_out, e0); end
    send_tap(16'd5);
    coef_valid = 1'b0;
    wait_done(found);
    total++; if (!found) begin bad++; $display("FAIL restart_done_timeout got=0 exp=1"); end
    for (int k = 0; k < HF; k++) begin
      e0[k*DW +: DW]  = 16'd5;
      e1[k*DW +: DW]  = 16'd5;
      e01[k*SW +: SW] = 17'd10;
    end
    total++; if (h0_out !== e0 || h1_out !== e1) begin bad++; $display("FAIL restart_h got h0=%0h h1=%0h exp=%0h", h0_out, h1_out, e0); end
    total++; if (h01_out !== e01) begin bad++; $display("FAIL restart_h01 got=%0h exp=%0h", h01_out, e01); end
  endtask

  task automatic test_commit_defer;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < NS; i++) begin
      data_in = pk(DW'(i), DW'(i));
      send_tap(DW'(-i));
    end
    coef_in    = 16'd55;
    coef_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      total++; if (coef_ready !== 1'b0 || coef_done !== 1'b0 || h0_out !== e0) begin bad++; $display("FAIL defer_hold got rdy=%0b done=%0b h0=%0h exp rdy=0 done=0 h0=%0h", coef_ready, coef_done, h0_out, e0); end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    coef_valid = 1'b0;
    for (int k = 0; k < HF; k++) begin
      e0[k*DW +: DW]  = DW'(-(2*k));
      e1[k*DW +: DW]  = DW'(-(2*k + 1));
      e01[k*SW +: SW] = SW'(-(4*k + 1));
    end
    total++; if (coef_done !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL defer_commit got done=%0b v=%0b exp done=1 v=0", coef_done, out_valid); end
    total++; if (h0_out !== e0 || h1_out !== e1) begin bad++; $display("FAIL defer_h got h0=%0h h1=%0h exp h0=%0h h1=%0h", h0_out, h1_out, e0, e1); end
    total++; if (h01_out !== e01) begin bad++; $display("FAIL defer_h01 got=%0h exp=%0h", h01_out, e01); end
    @(posedge clk); #1;
    total++; if (coef_done !== 1'b0 || coef_ready !== 1'b1) begin bad++; $display("FAIL defer_after got done=%0b rdy=%0b exp done=0 rdy=1", coef_done, coef_ready); end
  endtask

  task automatic test_async_reset;
    bit found;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    data_in   = pk(16'd7, 16'd8);
    for (int i = 0; i < 5; i++) send_tap(16'd1);
    #2 rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || data_a_out !== '0 || data_b_out !== '0 || data_ab_out !== '0) begin bad++; $display("FAIL arst_data got v=%0b a=%0h b=%0h ab=%0h exp 0", out_valid, data_a_out, data_b_out, data_ab_out); end
    total++; if (h0_out !== '0 || h1_out !== '0 || h01_out !== '0) begin bad++; $display("FAIL arst_bank got h0=%0h h1=%0h h01=%0h exp 0", h0_out, h1_out, h01_out); end
    total++; if (coef_done !== 1'b0 || coef_ready !== 1'b1) begin bad++; $display("FAIL arst_coef got done=%0b rdy=%0b exp done=0 rdy=1", coef_done, coef_ready); end
    in_valid   = 1'b0;
    coef_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < NS; i++) send_tap(16'd3);
    coef_valid = 1'b0;
    wait_done(found);
    total++; if (!found) begin bad++; $display("FAIL arst_reload_timeout got=0 exp=1"); end
    for (int k = 0; k < HF; k++) begin
      e0[k*DW +: DW]  = 16'd3;
      e01[k*SW +: SW] = 17'd6;
    end
    total++; if (h0_out !== e0 || h1_out !== e0 || h01_out !== e01) begin bad++; $display("FAIL arst_reload got h0=%0h h1=%0h h01=%0h exp h=%0h h01=%0h", h0_out, h1_out, h01_out, e0, e01); end
  endtask

  initial begin
    test_reset;
    test_coef_load;
    test_sum;
    test_backpressure;
    test_restart;
    test_commit_defer;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
